modbus_crc_engine: RTL

MODBUS_CRC_ENGINE -- requirements
Module: modbus_crc_engine

---
 rtl/modbus_crc_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/modbus_crc_engine.sv
// Streaming reflected CRC engine (Modbus CRC-16 by default), LANES bytes per beat, one beat per cycle.
// Optional residue check on crc_ok is enabled by defining MODBUS_CRC_RESIDUE_CHECK_EN.
module modbus_crc_engine #(
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = 16'hA001,
  parameter logic [CRC_W-1:0] INIT  = 16'hFFFF,
  parameter int               LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] data_in,
  input  logic [LANES-1:0]   in_keep,
  input  logic               in_last,
  output logic [CRC_W-1:0]   crc_out,
  output logic               crc_valid,
  input  logic               res_ready,
  output logic               crc_ok,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_r;
  logic [CRC_W-1:0] crc_r;
  logic [CRC_W-1:0] crc_base_s;
  logic [CRC_W-1:0] crc_next_s;
  logic             valid_r;
  logic             busy_r;
  logic             accept_s;

  // Kept lanes in ascending order, each byte LSB first; skipped lanes leave the register alone.
  function automatic logic [CRC_W-1:0] crc_lanes(input logic [CRC_W-1:0] seed,
                                                 input logic [8*LANES-1:0] data,
                                                 input logic [LANES-1:0] keep);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = seed;
    for (int k = 0; k < LANES; k++) begin
      if (keep[k]) begin
        for (int b = 0; b < 8; b++) begin
          fb = c[0] ^ data[8*k+b];
          c  = {1'b0, c[CRC_W-1:1]} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
      end
    end
    return c;
  endfunction

  // Beats are refused in HOLD, during an abort and while reset is held.
  assign in_ready  = (state_r != HOLD) & ~clr & ~rst;
  assign accept_s  = in_valid & in_ready;
  assign crc_out   = crc_r;
  assign crc_valid = valid_r;
  assign busy      = busy_r;

  // A frame's first beat starts from INIT rather than the retained previous result.
  always_comb begin
    crc_base_s = crc_r;
    if (state_r == IDLE) begin
      crc_base_s = INIT;
    end else begin
      crc_base_s = crc_r;
    end
    crc_next_s = crc_lanes(crc_base_s, data_in, in_keep);
  end

  // Frame FSM with registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      crc_r   <= INIT;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (clr) begin
      state_r <= IDLE;
      crc_r   <= INIT;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, RUN: begin
          if (accept_s) begin
            crc_r  <= crc_next_s;
            busy_r <= 1'b1;
            if (in_last) begin
              state_r <= HOLD;
              valid_r <= 1'b1;
            end else begin
              state_r <= RUN;
              valid_r <= 1'b0;
            end
          end else begin
            state_r <= state_r;
            valid_r <= valid_r;
            busy_r  <= busy_r;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= HOLD;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          crc_r   <= INIT;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MODBUS_CRC_RESIDUE_CHECK_EN
  logic ok_r;

  // A frame carrying its own CRC (low byte first) leaves a zero residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_r <= 1'b0;
    end else if (clr) begin
      ok_r <= 1'b0;
    end else if (accept_s && in_last) begin
      ok_r <= (crc_next_s == {CRC_W{1'b0}});
    end else if ((state_r == HOLD) && res_ready) begin
      ok_r <= 1'b0;
    end else begin
      ok_r <= ok_r;
    end
  end

  assign crc_ok = ok_r;
`else
  assign crc_ok = 1'b0;
`endif

endmodule
